// File: rtl/fm_bus_pkg.sv
// Shared types for the FM register bus host: bus widths, host FSM states and the queued command word.
package fm_bus_pkg;

  localparam int FM_ADDR_W = 6;
  localparam int FM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    RECOV = 3'd4
  } fm_host_state_t;

  typedef struct packed {
    logic                 rwn;
    logic [FM_ADDR_W-1:0] addr;
    logic [FM_DATA_W-1:0] data;
  } fm_cmd_t;

  // Phase counters count down to zero, so a state of N cycles loads N-1.
  function automatic logic [3:0] phase_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/fm_cmd_fifo.sv
// fm_cmd_fifo: synchronous command FIFO; a push is visible at the head one cycle later.
// Backpressure: full comes from the registered count only, so a push while full is refused even with a concurrent pop.
module fm_cmd_fifo
  import fm_bus_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fm_cmd_t       push_dat,
  input  logic          pop,
  output fm_cmd_t       pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  fm_cmd_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fm_bus_host.sv
// fm_bus_host: turns queued valid/ready commands into timed FM register-bus cycles; read data returns a cycle after capture.
// Backpressure: cmd_ready drops while the command FIFO is full; responses cannot be stalled.
module fm_bus_host
  import fm_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int WR_CYC     = 2,
  parameter int RD_CYC     = 2,
  parameter int RECOV_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rwn,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic [5:0] bus_addr,
  output logic       bus_rwn,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fm_cmd_t        cmd_in;
  fm_cmd_t        head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  count_d;
  logic           push;
  logic           pop;
  fm_host_state_t state;
  fm_host_state_t state_d;
  logic [3:0]     phase;
  logic [3:0]     phase_d;
  logic           cur_rwn;

  assign cmd_in    = {cmd_rwn, cmd_addr, cmd_data};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  fm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (cmd_in),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d = state;
    phase_d = phase;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
          phase_d = phase_load(SETUP_CYC);
        end
      end
      SETUP: begin
        if (phase == 4'd0) begin
          state_d = cur_rwn ? READ : WRITE;
          phase_d = cur_rwn ? phase_load(RD_CYC) : phase_load(WR_CYC);
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      WRITE, READ: begin
        if (phase == 4'd0) begin
          state_d = (RECOV_CYC == 0) ? IDLE : RECOV;
          phase_d = phase_load(RECOV_CYC);
        end else begin
          phase_d = phase - 4'd1;
        end
      end
      RECOV: begin
        if (phase == 4'd0) state_d = IDLE;
        else               phase_d = phase - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + CW'(1);
    else if (pop && !push) count_d = fifo_count - CW'(1);
  end

  // RWn and OE are separate flops updated on the same edges, so OE == ~RWn holds every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 4'd0;
      cur_rwn   <= 1'b1;
      bus_addr  <= '0;
      bus_dout  <= '0;
      bus_rwn   <= 1'b1;
      bus_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      busy      <= (state_d != IDLE) || (count_d != '0);
      rsp_valid <= 1'b0;
      if (pop) begin
        bus_addr <= head.addr;
        bus_dout <= head.data;
        cur_rwn  <= head.rwn;
      end
      if (state == SETUP && state_d == WRITE) begin
        bus_rwn <= 1'b0;
        bus_oe  <= 1'b1;
      end
      if (state == WRITE && state_d != WRITE) begin
        bus_rwn <= 1'b1;
        bus_oe  <= 1'b0;
      end
      if (state == READ && state_d != READ) begin
        rsp_data  <= bus_din;
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fm_bus_host.sv
// Directed bench for fm_bus_host: default instance plus a SETUP_CYC=3 / RECOV_CYC=0 instance.
module tb_fm_bus_host;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, cmd_rwn, rsp_valid, busy, bus_rwn, bus_oe;
  logic [5:0] cmd_addr, bus_addr;
  logic [7:0] cmd_data, rsp_data, bus_dout, bus_din;

  logic       b_cmd_valid, b_cmd_ready, b_cmd_rwn, b_rsp_valid, b_busy, b_bus_rwn, b_bus_oe;
  logic [5:0] b_cmd_addr, b_bus_addr;
  logic [7:0] b_cmd_data, b_rsp_data, b_bus_dout, b_bus_din;

  fm_bus_host dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rwn(cmd_rwn),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .bus_addr(bus_addr), .bus_rwn(bus_rwn), .bus_dout(bus_dout),
    .bus_oe(bus_oe), .bus_din(bus_din)
  );

  fm_bus_host #(.SETUP_CYC(3), .RECOV_CYC(0)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_rwn(b_cmd_rwn),
    .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .busy(b_busy), .bus_addr(b_bus_addr), .bus_rwn(b_bus_rwn), .bus_dout(b_bus_dout),
    .bus_oe(b_bus_oe), .bus_din(b_bus_din)
  );

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model of the FM core: latches writes while RWn is low.
  logic [7:0] regs [64];
  assign bus_din   = regs[bus_addr];
  assign b_bus_din = 8'h00;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) regs[i] = 8'h00;
      regs[63] = 8'h5C;
    end else if (!bus_rwn) begin
      regs[bus_addr] = bus_dout;
    end
  end

  logic        prev1 = 1'b1;
  int          low1 = 0, hi1 = 0, oe_err1 = 0, glitch1 = 0, rsp_cnt = 0, rsp_cyc = 0;
  logic [7:0]  last_rsp = 8'h00;
  int          st_cyc[$];
  int          st_len[$];
  int          st_gap[$];
  logic [13:0] st_ad[$];

  always @(negedge clk) begin
    if (bus_oe !== ~bus_rwn) oe_err1++;
    if (!bus_rwn) begin
      if (prev1) begin
        st_cyc.push_back(cyc);
        st_ad.push_back({bus_addr, bus_dout});
        st_gap.push_back(hi1);
        low1 = 0;
      end else if ({bus_addr, bus_dout} !== st_ad[$]) begin
        glitch1++;
      end
      low1++;
    end else begin
      if (!prev1) st_len.push_back(low1);
      hi1 = prev1 ? hi1 + 1 : 1;
    end
    prev1 = bus_rwn;
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp = rsp_data;
      rsp_cyc  = cyc;
    end
  end

  logic b_prev = 1'b1;
  int   b_hi = 0, b_oe_err = 0;
  int   b_st_cyc[$];
  int   b_gap[$];

  always @(negedge clk) begin
    if (b_bus_oe !== ~b_bus_rwn) b_oe_err++;
    if (!b_bus_rwn && b_prev) begin
      b_st_cyc.push_back(cyc);
      b_gap.push_back(b_hi);
    end
    if (b_bus_rwn) b_hi = b_prev ? b_hi + 1 : 1;
    b_prev = b_bus_rwn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rwn, input logic [5:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_rwn   = rwn;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int t = 0; t < bound && busy; t++) tick();
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int          n0, r0, acc, run, sp_err;
    logic        rdy;
    logic [13:0] e;
    cmd_valid = 0; cmd_rwn = 1; cmd_addr = 0; cmd_data = 0;
    b_cmd_valid = 0; b_cmd_rwn = 1; b_cmd_addr = 0; b_cmd_data = 0;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_rwn", bus_rwn, 1'b1);
    chk("rst_oe", bus_oe, 1'b0);
    chk("rst_addr", bus_addr, 6'h00);
    chk("rst_dout", bus_dout, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    tick();

    // Single write 0x05 <- 0xA7, followed cycle by cycle.
    push(1'b0, 6'h05, 8'hA7);
    chk("wr_busy_accept", busy, 1'b1);
    chk("wr_rwn_accept", bus_rwn, 1'b1);
    tick();
    chk("wr_setup_addr", bus_addr, 6'h05);
    chk("wr_setup_rwn", bus_rwn, 1'b1);
    tick();
    chk("wr_strobe1_rwn", bus_rwn, 1'b0);
    chk("wr_strobe1_oe", bus_oe, 1'b1);
    chk("wr_strobe1_dout", bus_dout, 8'hA7);
    tick();
    chk("wr_strobe2_rwn", bus_rwn, 1'b0);
    tick();
    chk("wr_recov_rwn", bus_rwn, 1'b1);
    chk("wr_recov_busy", busy, 1'b1);
    tick();
    chk("wr_idle_busy", busy, 1'b0);
    chk("wr_strobe_len", st_len[0], 2);
    chk("wr_strobe_ad", st_ad[0], {6'h05, 8'hA7});

    // Read 0x3F; the model returns 0x5C.
    n0 = st_cyc.size();
    push(1'b1, 6'h3F, 8'h00);
    tick(); tick(); tick();
    chk("rd_no_early_rsp", rsp_valid, 1'b0);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_data", rsp_data, 8'h5C);
    tick();
    chk("rd_rsp_pulse", rsp_valid, 1'b0);
    chk("rd_idle_busy", busy, 1'b0);
    chk("rd_rsp_count", rsp_cnt, 1);
    chk("rd_no_strobe", st_cyc.size(), n0);

    // Burst of six writes with cmd_valid held high.
    st_cyc.delete(); st_ad.delete(); st_len.delete(); st_gap.delete();
    acc = 0; run = -1;
    cmd_valid = 1'b1; cmd_rwn = 1'b0; cmd_addr = 6'd0; cmd_data = 8'h40;
    for (int t = 0; t < 100 && acc < 6; t++) begin
      rdy = cmd_ready;
      tick();
      if (rdy) acc++;
      else if (run < 0) run = acc;
      cmd_addr = 6'(acc);
      cmd_data = 8'(8'h40 + acc);
    end
    cmd_valid = 1'b0;
    chk("burst_accepts", acc, 6);
    chk("burst_run_before_full", run, 5);
    wait_idle("burst_idle", 200);
    chk("burst_count", st_cyc.size(), 6);
    sp_err = 0;
    for (int k = 0; k < 6 && k < st_ad.size(); k++) begin
      e = {k[5:0], 8'(8'h40 + k[7:0])};
      chk("burst_order", st_ad[k], e);
      if (k > 0 && st_cyc[k] - st_cyc[k-1] != 5) sp_err++;
    end
    chk("burst_spacing", sp_err, 0);

    // Mixed write / read / write.
    st_cyc.delete(); st_ad.delete(); st_len.delete(); st_gap.delete();
    r0 = rsp_cnt;
    push(1'b0, 6'h10, 8'h11);
    push(1'b1, 6'h10, 8'h00);
    push(1'b0, 6'h11, 8'h22);
    wait_idle("mix_idle", 200);
    chk("mix_strobes", st_cyc.size(), 2);
    chk("mix_first", st_ad[0], {6'h10, 8'h11});
    chk("mix_second", st_ad[1], {6'h11, 8'h22});
    chk("mix_rsp_count", rsp_cnt - r0, 1);
    chk("mix_rsp_data", last_rsp, 8'h11);
    chk("mix_rsp_order", (rsp_cyc > st_cyc[0]) && (rsp_cyc < st_cyc[1]), 1'b1);
    chk("mix_gap", st_gap[1], 8);

    // Reset asserted in the second WRITE cycle, with commands still queued.
    push(1'b0, 6'h20, 8'h33);
    push(1'b0, 6'h21, 8'h34);
    push(1'b1, 6'h3F, 8'h00);
    for (int t = 0; t < 50 && bus_rwn; t++) tick();
    chk("rst_test_strobe", bus_rwn, 1'b0);
    tick();
    chk("rst_test_write2", bus_rwn, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rwn", bus_rwn, 1'b1);
    chk("async_oe", bus_oe, 1'b0);
    chk("async_busy", busy, 1'b0);
    r0 = rsp_cnt;
    n0 = st_cyc.size();
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_no_rsp", rsp_cnt, r0);
    chk("post_rst_no_strobe", st_cyc.size(), n0);

    // SETUP_CYC=3, RECOV_CYC=0 instance: back-to-back writes.
    b_cmd_valid = 1'b1; b_cmd_rwn = 1'b0; b_cmd_addr = 6'h01; b_cmd_data = 8'h01;
    tick();
    b_cmd_addr = 6'h02; b_cmd_data = 8'h02;
    tick();
    b_cmd_valid = 1'b0;
    for (int t = 0; t < 100 && b_busy; t++) tick();
    chk("b_idle", b_busy, 1'b0);
    chk("b_strobes", b_st_cyc.size(), 2);
    chk("b_spacing", b_st_cyc[1] - b_st_cyc[0], 6);
    chk("b_gap", b_gap[1], 4);
    chk("b_oe_contract", b_oe_err, 0);

    chk("oe_contract", oe_err1, 0);
    chk("addr_data_stable", glitch1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
